multdiv_seq: RTL and testbench



---
 rtl/multdiv_pkg.sv | 26 ++
 rtl/multdiv_seq_if.sv | 32 +++
 rtl/multdiv_opsel.sv | 61 ++++++
 rtl/multdiv_seq.sv | 178 +++++++++++++++++
 tb/tb_multdiv_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITERS = 32;

  localparam logic [WIDTH-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [WIDTH-1:0] MINUS_ONE = 32'hFFFF_FFFF;

  // Booth pair {LO[0], q}
  localparam logic [1:0] BoothNop0 = 2'b00;
  localparam logic [1:0] BoothAdd  = 2'b01;
  localparam logic [1:0] BoothSub  = 2'b10;
  localparam logic [1:0] BoothNop1 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StMIter,
    StDNegA,
    StDNegB,
    StDIter,
    StDNegQ,
    StDone
  } state_e;

endpackage

// File: rtl/multdiv_seq_if.sv
// Issue-side and shared-adder signals of the multiply/divide sequencer.
interface multdiv_seq_if;
  import multdiv_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_ovf;

  // Environment side: issue logic plus the external adder
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, add_s, add_ovf,
    input  data_result, data_exception, data_resultRDY, busy, add_a, add_b, add_cin
  );

  // Sequencer side
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, add_s, add_ovf,
    output data_result, data_exception, data_resultRDY, busy, add_a, add_b, add_cin
  );

endinterface

// File: rtl/multdiv_opsel.sv
// Combinational operand mux for the shared adder, driven by sequencer state.
module multdiv_opsel
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  state_e           state_i,
  input  logic [WIDTH-1:0] hi_i,     // HI (multiply) / R (divide)
  input  logic [WIDTH-1:0] lo_i,     // LO (multiply) / Q (divide)
  input  logic [WIDTH-1:0] m_i,      // M (multiply) / D (divide)
  input  logic             booth_i,  // Booth history bit q
  input  logic             sign_i,   // quotient sign
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_cin_o
);

  // Select adder operands; IDLE and DONE leave the adder at 0/0/0
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    unique case (state_i)
      StMIter: begin
        add_a_o = hi_i;
        unique case ({lo_i[0], booth_i})
          BoothAdd: add_b_o = m_i;
          BoothSub: begin
            add_b_o   = ~m_i;
            add_cin_o = 1'b1;
          end
          default: add_b_o = '0;
        endcase
      end
      StDNegA: begin
        // 0 + ~x + 1 negates; INT_MIN maps to itself and is read as unsigned 2^31
        add_b_o   = lo_i[WIDTH-1] ? ~lo_i : lo_i;
        add_cin_o = lo_i[WIDTH-1];
      end
      StDNegB: begin
        add_b_o   = m_i[WIDTH-1] ? ~m_i : m_i;
        add_cin_o = m_i[WIDTH-1];
      end
      StDIter: begin
        add_a_o   = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
        add_b_o   = ~m_i;
        add_cin_o = 1'b1;
      end
      StDNegQ: begin
        add_b_o   = sign_i ? ~lo_i : lo_i;
        add_cin_o = sign_i;
      end
      default: begin
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) and divide (restoring on
// magnitudes) sharing one external adder.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clock,
  input logic          reset_n,
  multdiv_seq_if.slave bus
);

  if (WIDTH != 32) begin : gen_width_check
    $fatal(1, "multdiv_seq: only WIDTH == 32 is supported");
  end

  state_e           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;        // HI / remainder R
  logic [WIDTH-1:0] lo_q, lo_d;        // LO / quotient Q
  logic [WIDTH-1:0] m_q, m_d;          // multiplicand M / divisor D
  logic             booth_q, booth_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;

  logic             start;
  logic             last_iter;
  logic             msign;
  logic [WIDTH-1:0] mult_hi, mult_lo;
  logic [WIDTH-1:0] rs;
  logic             no_borrow;

  multdiv_opsel #(
    .WIDTH (WIDTH)
  ) u_opsel (
    .state_i   (state_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .m_i       (m_q),
    .booth_i   (booth_q),
    .sign_i    (sign_q),
    .add_a_o   (add_a),
    .add_b_o   (add_b),
    .add_cin_o (add_cin)
  );

  // Datapath helpers derived from the adder return
  always_comb begin
    start     = bus.ctrl_MULT | bus.ctrl_DIV;
    last_iter = (count_q == 5'(ITERS - 1));
    // True sign of the 33-bit Booth partial sum
    msign     = bus.add_s[WIDTH-1] ^ bus.add_ovf;
    mult_hi   = {msign, bus.add_s[WIDTH-1:1]};
    mult_lo   = {bus.add_s[0], lo_q[WIDTH-1:1]};
    rs        = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    // D is a magnitude below 2^31, so Rs[31] set always means Rs >= D
    no_borrow = rs[WIDTH-1] | ~bus.add_s[WIDTH-1];
  end

  // Next-state and register update; a start in any state (re)loads operands
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    booth_d  = booth_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;

    if (start) begin
      count_d = '0;
      hi_d    = '0;
      booth_d = 1'b0;
      if (bus.ctrl_MULT) begin
        state_d = StMIter;
        lo_d    = bus.data_operandB;
        m_d     = bus.data_operandA;
        sign_d  = 1'b0;
      end else begin
        lo_d    = bus.data_operandA;
        m_d     = bus.data_operandB;
        sign_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        if (bus.data_operandB == '0) begin
          state_d  = StDone;
          result_d = '0;
          exc_d    = 1'b1;
        end else if (bus.data_operandB == INT_MIN) begin
          // |A| never exceeds 2^31, so the quotient is 1 only for INT_MIN itself
          state_d  = StDone;
          result_d = (bus.data_operandA == INT_MIN) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
          exc_d    = 1'b0;
        end else begin
          state_d = StDNegA;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StMIter: begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          booth_d = lo_q[0];
          count_d = count_q + 5'd1;
          if (last_iter) begin
            state_d  = StDone;
            result_d = mult_lo;
            exc_d    = (mult_hi != {WIDTH{mult_lo[WIDTH-1]}});
          end
        end
        StDNegA: begin
          lo_d    = bus.add_s;
          state_d = StDNegB;
        end
        StDNegB: begin
          m_d     = bus.add_s;
          state_d = StDIter;
        end
        StDIter: begin
          hi_d    = no_borrow ? bus.add_s : rs;
          lo_d    = {lo_q[WIDTH-2:0], no_borrow};
          count_d = count_q + 5'd1;
          if (last_iter) begin
            state_d = StDNegQ;
          end
        end
        StDNegQ: begin
          lo_d     = bus.add_s;
          result_d = bus.add_s;
          // A positive quotient with bit 31 set is only INT_MIN / -1
          exc_d    = ~sign_q & lo_q[WIDTH-1];
          state_d  = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      booth_q  <= 1'b0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      booth_q  <= booth_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.add_a          = add_a;
  assign bus.add_b          = add_b;
  assign bus.add_cin        = add_cin;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == StDone);
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq with a behavioural shared adder.
module tb_multdiv_seq;
  import multdiv_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exc;
    int          start;
    int          lat;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  multdiv_seq_if bus ();

  multdiv_seq #(
    .WIDTH (32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural 32-bit adder with signed overflow = c32 ^ c31
  logic [32:0] add_full;
  logic [31:0] add_low;
  always_comb begin
    add_full    = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_cin);
    add_low     = {1'b0, bus.add_a[30:0]} + {1'b0, bus.add_b[30:0]} + 32'(bus.add_cin);
    bus.add_s   = add_full[31:0];
    bus.add_ovf = add_full[32] ^ add_low[31];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every completion pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && bus.data_resultRDY === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rdy: got rdy=1 expected no pulse (cyc=%0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_result"}, bus.data_result, e.res);
          chk({e.name, "_exc"}, 32'(bus.data_exception), 32'(e.exc));
          chk({e.name, "_latency"}, 32'(cyc - e.start + 1), 32'(e.lat));
        end
      end
    end
  end

  // Issue one start pulse; returns at the negedge after the start edge
  task automatic issue(input logic mult, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input string name,
                       input logic [31:0] res, input logic exc, input int lat);
    exp_t e;
    @(negedge clock);
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (push) begin
      e.name  = name;
      e.res   = res;
      e.exc   = exc;
      e.start = cyc + 1;
      e.lat   = lat;
      sb_q.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 120;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int nbusy;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(negedge clock);
    chk("rst_result", bus.data_result, 32'h0);
    chk("rst_exc", 32'(bus.data_exception), 32'h0);
    chk("rst_rdy", 32'(bus.data_resultRDY), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_adder", {bus.add_a | bus.add_b}, 32'h0);
    chk("rst_cin", 32'(bus.add_cin), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 7 * -3, plus busy width
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, "mul_7x-3", 32'hFFFF_FFEB, 1'b0, 33);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy !== 1'b1) break;
      nbusy++;
      @(negedge clock);
    end
    chk("mul_busy_cycles", 32'(nbusy), 32'd33);
    wait_done("mul_7x-3");
    chk("idle_add_a", bus.add_a, 32'h0);
    chk("idle_add_b", bus.add_b, 32'h0);

    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, "mul_ovf", 32'h0, 1'b1, 33);
    wait_done("mul_ovf");
    issue(1'b1, 1'b0, INT_MIN, 32'd1, 1'b1, "mul_min_x1", 32'h8000_0000, 1'b0, 33);
    wait_done("mul_min_x1");

    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_-7_2", 32'hFFFF_FFFD, 1'b0, 36);
    wait_done("div_-7_2");
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, "div_100_7", 32'd14, 1'b0, 36);
    wait_done("div_100_7");
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, "div_by_zero", 32'h0, 1'b1, 1);
    wait_done("div_by_zero");
    issue(1'b0, 1'b1, INT_MIN, INT_MIN, 1'b1, "div_min_min", 32'd1, 1'b0, 1);
    wait_done("div_min_min");
    issue(1'b0, 1'b1, INT_MIN, MINUS_ONE, 1'b1, "div_min_-1", 32'h8000_0000, 1'b1, 36);
    wait_done("div_min_-1");

    // Asynchronous reset in the middle of a divide: no completion expected
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, "", 32'h0, 1'b0, 0);
    repeat (19) @(posedge clock);
    chk("mid_div_busy", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_result", bus.data_result, 32'h0);
    chk("arst_exc", 32'(bus.data_exception), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_add_b", bus.add_b, 32'h0);
    chk("arst_cin", 32'(bus.add_cin), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    issue(1'b1, 1'b0, 32'd2, 32'd2, 1'b1, "mul_2x2", 32'd4, 1'b0, 33);
    wait_done("mul_2x2");

    // Multiply aborted by a divide started 10 cycles later: RDY 46 cycles after the multiply start
    issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, "", 32'h0, 1'b0, 0);
    repeat (9) @(posedge clock);
    issue(1'b0, 1'b1, 32'd9, 32'd3, 1'b1, "abort_div_9_3", 32'd3, 1'b0, 36);
    wait_done("abort_div_9_3");

    // Both starts together: multiply wins
    issue(1'b1, 1'b1, 32'd6, 32'd2, 1'b1, "both_starts", 32'd12, 1'b0, 33);
    wait_done("both_starts");

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
